instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch unit: owns the PC, fetches 32-bit words from instruction
//   memory over a req/ack handshake, and presents each instruction (and its opcode
//   field) to the decode stage (main decoder + ALU decoder) via valid/ready.
//   Accepts branch redirects from execute. It is the producer side of the opcode
//   stream that the decoder consumes.
// PARAMETERS
//   ADDR_W    32     byte-address width of PC / imem_addr
//   RESET_PC  32'h0  PC value after reset; must be word aligned
// PORTS
//   clk            in   1       single clock; all state updates on posedge
//   rst_n          in   1       asynchronous, active-low reset
//   imem_req       out  1       fetch request to instruction memory
//   imem_addr      out  ADDR_W  word-aligned fetch address; stable while imem_req=1
//   imem_ack       in   1       memory completes request this cycle
//   imem_rdata     in   32      instruction word; valid only when imem_ack=1
//   redirect       in   1       branch taken; 1-cycle pulse from execute
//   redirect_pc    in   ADDR_W  branch target; bits [1:0] ignored (forced 00)
//   instr          out  32      fetched instruction
//   instr_pc       out  ADDR_W  address of instr
//   opcode         out  6       instr[31:26], drives the main decoder
//   instr_valid    out  1       instr/instr_pc/opcode are valid
//   instr_ready    in   1       decode accepts instruction when valid&ready
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, imem_req=0,
//     imem_addr=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0, flush=0.
//   States: IDLE, FETCH, HOLD.
//   IDLE : one cycle after reset release -> FETCH. redirect here loads pc.
//   FETCH: imem_req=1, imem_addr=pc (held constant until ack).
//     ack & ~flush & ~redirect: instr<=imem_rdata, instr_pc<=pc, valid<=1,
//       pc<=pc+4, -> HOLD.
//     ack & (flush | redirect): data discarded; pc<=redirect ? redirect_pc
//       : saved target; flush<=0; stay FETCH (new req next cycle, req may
//       drop for 0 cycles).
//     ~ack & redirect: cannot change imem_addr mid-request; save target,
//       flush<=1; stay FETCH. A later redirect overwrites the saved target.
//   HOLD : instr_valid=1, imem_req=0; outputs stable until handshake.
//     redirect (priority over ready): valid<=0, pc<=redirect_pc, -> FETCH.
//     valid & ready: valid<=0, -> FETCH (next address is pc already +4).
//   Throughput: min 2 cycles/instruction with 1-cycle-ack memory (FETCH->HOLD);
//     a fetch latency of N cycles adds N-1.
//   Arithmetic: pc+4 modulo 2^ADDR_W (wraps from max word to 0). pc[1:0]
//     always 00; redirect_pc[1:0] dropped.
//   imem_ack while imem_req=0 is ignored. opcode is purely instr[31:26].
//   Reset mid-request: all state cleared immediately; an ack in the
//     reset-release cycle is ignored (state is IDLE).
// STRUCTURE
//   Shared package mips_pkg: INSTR_W=32, opcode constants OP_RTYPE 6'b000000,
//     OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100 (also used by the
//     main decoder), fetch state encoding typedef.
//   One sub-module: fetch_pc (PC register, +4 adder, redirect/saved-target mux,
//     flush flag). FSM and instruction register stay in instr_fetch.
// TESTING
//   1 Reset release, ack every req, ready=1 -> imem_addr 0,4,8,...; instr_pc
//     matches; instr_valid every 2nd cycle; opcode = rdata[31:26].
//   2 rdata=32'h8C220004 at addr 0 -> opcode 6'b100011; hold ready=0 5 cycles
//     -> instr/instr_pc/valid stable, imem_req=0 throughout.
//   3 Memory ack delayed 3 cycles, redirect to 32'h40 in 2nd wait cycle ->
//     imem_addr stays 0 until ack, that word never valid, next req addr 0x40.
//   4 In HOLD with ready=1 and redirect=1 (target 32'h103) -> instruction not
//     consumed by fetch state, valid drops, next imem_addr 32'h100.
//   5 RESET_PC=32'hFFFFFFFC -> first fetch 0xFFFFFFFC, second fetch 0x0.
//   6 Assert rst_n=0 with req outstanding -> req=0, valid=0 asynchronously;
//     after release, first req at RESET_PC one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction width, the opcodes used by the
// main decoder, and the fetch state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory req/ack port, branch redirect from
// execute, and the valid/ready instruction stream towards decode.
interface instr_fetch_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [5:0]         opcode;
    logic               instr_valid;
    logic               instr_ready;

    // master = the fetch unit; slave = memory/execute/decode environment
    modport master (
        output imem_req, imem_addr, instr, instr_pc, opcode, instr_valid,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, opcode, instr_valid,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_pc.sv
// Program counter with +4 increment, redirect / saved-target loading and the
// flush flag that marks an in-flight fetch as stale.
module fetch_pc #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              take_i,
    input  logic              save_i,
    input  logic              load_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flush_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] saved_q, saved_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] target;
    logic [1:0]        unused_target_lsbs;

    // Branch targets are word addresses; the byte offset is discarded.
    assign target             = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_target_lsbs = redirect_pc_i[1:0];

    always_comb begin
        pc_d    = pc_q;
        saved_d = saved_q;
        flush_d = flush_q;
        if (inc_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end else if (take_i) begin
            // Stale fetch completed: jump to the freshest known target.
            pc_d    = redirect_i ? target : saved_q;
            flush_d = 1'b0;
        end else if (save_i) begin
            saved_d = target;
            flush_d = 1'b1;
        end else if (load_i) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            saved_q <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            saved_q <= saved_d;
            flush_q <= flush_d;
        end
    end

    assign pc_o    = pc_q;
    assign flush_o = flush_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer and instruction register,
// feeding decode over valid/ready and accepting redirects from execute.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master fif
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

    logic              pc_inc, pc_take, pc_save, pc_load;
    logic [ADDR_W-1:0] pc;
    logic              flush;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_i         (pc_inc),
        .take_i        (pc_take),
        .save_i        (pc_save),
        .load_i        (pc_load),
        .redirect_i    (fif.redirect),
        .redirect_pc_i (fif.redirect_pc),
        .pc_o          (pc),
        .flush_o       (flush)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_inc     = 1'b0;
        pc_take    = 1'b0;
        pc_save    = 1'b0;
        pc_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                pc_load = fif.redirect;
            end
            ST_FETCH: begin
                if (fif.imem_ack) begin
                    if (flush || fif.redirect) begin
                        pc_take = 1'b1;
                    end else begin
                        instr_d    = fif.imem_rdata;
                        instr_pc_d = pc;
                        pc_inc     = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (fif.redirect) begin
                    // Address must stay put until the memory answers.
                    pc_save = 1'b1;
                end
            end
            ST_HOLD: begin
                if (fif.redirect) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end else if (fif.instr_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs come straight from registers so reset clears them asynchronously.
    assign fif.imem_req    = (state_q == ST_FETCH);
    assign fif.imem_addr   = pc;
    assign fif.instr       = instr_q;
    assign fif.instr_pc    = instr_pc_q;
    assign fif.opcode      = opcode_of(instr_q);
    assign fif.instr_valid = (state_q == ST_HOLD);

endmodule
